// File: rtl/keypad_uart_tx_fifo_if.sv
// Key-entry and UART status signals of keypad_uart_tx_fifo.
// The master side (keypad encoder) supplies the key code and transmit key.
// The slave side (the transmitter) returns the line and the queue status.
interface keypad_uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

  logic [3:0]         keypad_in;
  logic               transmit_key;
  logic               tx;
  logic               busy;
  logic [COUNT_W-1:0] fifo_count;
  logic               fifo_full;
  logic               overflow;
  logic               rst_led;

  modport master (
    output keypad_in, transmit_key,
    input  tx, busy, fifo_count, fifo_full, overflow, rst_led
  );

  modport slave (
    input  keypad_in, transmit_key,
    output tx, busy, fifo_count, fifo_full, overflow, rst_led
  );
endinterface

// File: rtl/keypad_uart_tx_fifo.sv
// keypad_uart_tx_fifo: keypad push -> ASCII -> FIFO -> UART serialiser.
// Each rising edge of transmit_key queues one character.
// The UART drains the queue with exactly one idle cycle between frames.
// Optional feature macro: KEYPAD_UART_TX_PARITY_EN (even parity bit after
// data bit 7). When undefined, frames are start + 8 data + stop bit(s).
module keypad_uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FIFO_DEPTH   = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  keypad_uart_tx_fifo_if.slave bus
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W  = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]         STOP_LAST  = 3'(STOP_BITS - 1);
  localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef KEYPAD_UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  // Keypad code to ASCII character.
  function automatic logic [7:0] ascii_of(input logic [3:0] code);
    logic [7:0] ch;
    case (code)
      4'hE:                   ch = 8'h2A;
      4'hF:                   ch = 8'h23;
      4'hA, 4'hB, 4'hC, 4'hD: ch = 8'h41 + {4'h0, code - 4'hA};
      default:                ch = 8'h30 + {4'h0, code};
    endcase
    return ch;
  endfunction

`ifdef KEYPAD_UART_TX_PARITY_EN
  // Even parity: makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  // Edge detect and FIFO storage
  logic               key_d_r;
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [COUNT_W-1:0] count_r;
  logic [COUNT_W-1:0] count_next_s;
  logic               full_r;
  logic               overflow_r;
  logic               rst_led_r;
  logic               push_s;
  logic               full_s;
  logic               push_ok_s;
  logic               drop_s;

  // Serialiser
  state_t             state_r;
  state_t             state_next_s;
  logic [BAUD_W-1:0]  baud_r;
  logic [BAUD_W-1:0]  baud_next_s;
  logic [2:0]         bit_r;
  logic [2:0]         bit_next_s;
  logic [7:0]         shift_r;
  logic               pop_s;
  logic               tx_r;
  logic               tx_next_s;
  logic               busy_r;
  logic               busy_next_s;

  assign bus.tx         = tx_r;
  assign bus.busy       = busy_r;
  assign bus.fifo_count = count_r;
  assign bus.fifo_full  = full_r;
  assign bus.overflow   = overflow_r;
  assign bus.rst_led    = rst_led_r;

  // Track the previous level of transmit_key for push detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_d_r <= 1'b0;
    end else begin
      key_d_r <= bus.transmit_key;
    end
  end

  // Push/drop decisions; a full FIFO still accepts a push when it pops.
  always_comb begin
    push_s       = bus.transmit_key & ~key_d_r;
    full_s       = (count_r == COUNT_FULL);
    push_ok_s    = push_s & (~full_s | pop_s);
    drop_s       = push_s & full_s & ~pop_s;
    count_next_s = count_r;
    if (push_ok_s && !pop_s) begin
      count_next_s = count_r + COUNT_W'(1);
    end else if (!push_ok_s && pop_s) begin
      count_next_s = count_r - COUNT_W'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // FIFO storage write; contents need no reset since pointers are cleared.
  always_ff @(posedge clk) begin
    if (push_ok_s && !rst) begin
      fifo_mem[wr_ptr_r] <= ascii_of(bus.keypad_in);
    end
  end

  // Pointers, occupancy, full flag and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == COUNT_FULL);
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Reset indicator LED: dark while reset is applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_led_r <= 1'b0;
    end else begin
      rst_led_r <= 1'b1;
    end
  end

  // Frame sequencing: next state, baud counter and bit index.
  always_comb begin
    state_next_s = state_r;
    baud_next_s  = baud_r;
    bit_next_s   = bit_r;
    pop_s        = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (count_r != '0) begin
          pop_s        = 1'b1;
          state_next_s = S_START;
          baud_next_s  = '0;
          bit_next_s   = 3'd0;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_START: begin
        if (baud_r == BAUD_LAST) begin
          state_next_s = S_DATA;
          baud_next_s  = '0;
          bit_next_s   = 3'd0;
        end else begin
          baud_next_s = baud_r + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_r == BAUD_LAST) begin
          baud_next_s = '0;
          if (bit_r == 3'd7) begin
`ifdef KEYPAD_UART_TX_PARITY_EN
            state_next_s = S_PARITY;
`else
            state_next_s = S_STOP;
`endif
            bit_next_s = 3'd0;
          end else begin
            bit_next_s = bit_r + 3'd1;
          end
        end else begin
          baud_next_s = baud_r + BAUD_W'(1);
        end
      end
`ifdef KEYPAD_UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_r == BAUD_LAST) begin
          state_next_s = S_STOP;
          baud_next_s  = '0;
          bit_next_s   = 3'd0;
        end else begin
          baud_next_s = baud_r + BAUD_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_r == BAUD_LAST) begin
          baud_next_s = '0;
          if (bit_r == STOP_LAST) begin
            state_next_s = S_IDLE;
            bit_next_s   = 3'd0;
          end else begin
            bit_next_s = bit_r + 3'd1;
          end
        end else begin
          baud_next_s = baud_r + BAUD_W'(1);
        end
      end
      default: begin
        state_next_s = S_IDLE;
        baud_next_s  = '0;
        bit_next_s   = 3'd0;
      end
    endcase
  end

  // Line level and busy for the state being entered, so both are registered.
  always_comb begin
    tx_next_s   = 1'b1;
    busy_next_s = 1'b1;
    case (state_next_s)
      S_IDLE: begin
        tx_next_s   = 1'b1;
        busy_next_s = 1'b0;
      end
      S_START: begin
        tx_next_s = 1'b0;
      end
      S_DATA: begin
        tx_next_s = shift_r[bit_next_s];
      end
`ifdef KEYPAD_UART_TX_PARITY_EN
      S_PARITY: begin
        tx_next_s = even_parity(shift_r);
      end
`endif
      S_STOP: begin
        tx_next_s = 1'b1;
      end
      default: begin
        tx_next_s   = 1'b1;
        busy_next_s = 1'b0;
      end
    endcase
  end

  // Serialiser registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      baud_r  <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      baud_r  <= baud_next_s;
      bit_r   <= bit_next_s;
      if (pop_s) begin
        shift_r <= fifo_mem[rd_ptr_r];
      end
      tx_r   <= tx_next_s;
      busy_r <= busy_next_s;
    end
  end

endmodule

// File: tb/tb_keypad_uart_tx_fifo.sv
// Testbench for keypad_uart_tx_fifo: random and directed key presses checked
// against a queue-based reference model and a UART line decoder.
module tb_keypad_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int STOP  = 1;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef KEYPAD_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = (10 + PAR + STOP - 1) * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  keypad_uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  keypad_uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH),
    .STOP_BITS(STOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  logic [7:0] m_cur  = 8'h00;
  int         m_rem  = 0;
  logic       m_key_d = 1'b0;
  logic       m_ovf  = 1'b0;
  logic       m_led  = 1'b0;

  // Line decoder state (observes the DUT)
  logic [7:0] rx_q[$];
  int         rise_cyc[$];
  logic [7:0] rx_byte = 8'h00;
  logic       rx_active = 1'b0;
  logic       prev_busy = 1'b0;
  int         rx_t = 0;
  int         cyc = 0;

  function automatic logic [7:0] ascii_ref(input logic [3:0] c);
    int v;
    v = int'(c);
    if (v < 10) return 8'(48 + v);
    else if (v < 14) return 8'(65 + v - 10);
    else if (v == 14) return 8'h2A;
    else return 8'h23;
  endfunction

  // Expected line level from the frame position of the model.
  function automatic logic exp_tx();
    int e;
    int slot;
    if (m_rem == 0) return 1'b1;
    e = FRAME - m_rem;
    slot = e / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_cur[slot-1];
    if (PAR == 1 && slot == 9) return ^m_cur;
    return 1'b1;
  endfunction

  // Drive one cycle, advance the model at the edge, then decode the DUT line.
  task automatic step(input logic key, input logic [3:0] code, input logic r);
    logic push;
    int   idx;
    rst = r;
    bus.transmit_key = key;
    bus.keypad_in = code;
    @(posedge clk);
    push = key && !m_key_d;
    if (r) begin
      m_q.delete();
      m_rem = 0;
      m_ovf = 1'b0;
      m_key_d = 1'b0;
      m_led = 1'b0;
    end else begin
      m_led = 1'b1;
      m_key_d = key;
      if (m_rem > 0) m_rem--;
      else if (m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        m_sent.push_back(m_cur);
        m_rem = FRAME;
      end
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(ascii_ref(code));
        else m_ovf = 1'b1;
      end
    end
    #1;
    cyc++;
    if (r) begin
      rx_active = 1'b0;
    end else begin
      if (!rx_active && bus.busy && !prev_busy) begin
        rx_active = 1'b1;
        rx_t = 0;
        rise_cyc.push_back(cyc);
      end else if (rx_active) begin
        rx_t++;
      end
      if (rx_active) begin
        if (rx_t >= CPB && rx_t < 9 * CPB && (rx_t % CPB) == CPB / 2) begin
          idx = rx_t / CPB - 1;
          rx_byte[idx[2:0]] = bus.tx;
        end
        if (rx_t == FRAME - 1) begin
          rx_q.push_back(rx_byte);
          rx_active = 1'b0;
        end
      end
    end
    prev_busy = bus.busy;
  endtask

  task automatic clear_logs();
    rx_q.delete();
    m_sent.delete();
    rise_cyc.delete();
  endtask

  task automatic test_reset();
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b1);
    n_cmp++; if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.fifo_count !== CW'(0)) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
    n_cmp++; if (bus.fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.fifo_full); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
    n_cmp++; if (bus.rst_led !== 1'b0) begin n_fail++; $display("FAIL reset_led: got %b want 0", bus.rst_led); end
    step(1'b0, 4'h0, 1'b0);
    n_cmp++; if (bus.rst_led !== 1'b1) begin n_fail++; $display("FAIL release_led: got %b want 1", bus.rst_led); end
  endtask

  task automatic test_single();
    int busy_n;
    clear_logs();
    step(1'b1, 4'h5, 1'b0);
    n_cmp++; if (bus.fifo_count !== CW'(1)) begin n_fail++; $display("FAIL single_count_push: got %0d want 1", bus.fifo_count); end
    n_cmp++; if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_push: got %b want 1", bus.tx); end
    step(1'b0, 4'h5, 1'b0);
    n_cmp++; if (bus.tx !== 1'b0) begin n_fail++; $display("FAIL single_start: got %b want 0", bus.tx); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    n_cmp++; if (bus.fifo_count !== CW'(0)) begin n_fail++; $display("FAIL single_count_pop: got %0d want 0", bus.fifo_count); end
    busy_n = 1;
    for (int i = 0; i < FRAME + 4; i++) begin
      step(1'b0, 4'h5, 1'b0);
      n_cmp++; if (bus.tx !== exp_tx()) begin n_fail++; $display("FAIL single_tx@%0d: got %b want %b", i, bus.tx, exp_tx()); end
      if (bus.busy) busy_n++;
    end
    n_cmp++; if (busy_n !== FRAME) begin n_fail++; $display("FAIL single_busy_len: got %0d want %0d", busy_n, FRAME); end
    n_cmp++; if (rx_q.size() !== 1) begin n_fail++; $display("FAIL single_frames: got %0d want 1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      n_cmp++; if (rx_q[0] !== 8'h35) begin n_fail++; $display("FAIL single_char: got %h want 35", rx_q[0]); end
    end
  endtask

  task automatic test_parity();
    logic [3:0] codes [2];
    logic [7:0] ch;
    logic       want;
    int         busy_n;
    codes[0] = 4'h1;
    codes[1] = 4'h0;
    for (int k = 0; k < 2; k++) begin
      ch = ascii_ref(codes[k]);
      want = (PAR == 1) ? ^ch : 1'b1;
      step(1'b1, codes[k], 1'b0);
      step(1'b0, codes[k], 1'b0);
      busy_n = 1;
      for (int i = 1; i < FRAME + 3; i++) begin
        step(1'b0, codes[k], 1'b0);
        if (bus.busy) busy_n++;
        if (i == 9 * CPB + CPB / 2) begin
          n_cmp++; if (bus.tx !== want) begin n_fail++; $display("FAIL parity_bit[%0d]: got %b want %b", k, bus.tx, want); end
        end
      end
      n_cmp++; if (busy_n !== (10 + PAR) * CPB) begin n_fail++; $display("FAIL parity_len[%0d]: got %0d want %0d", k, busy_n, (10 + PAR) * CPB); end
    end
  endtask

  task automatic test_held();
    clear_logs();
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 4'hE, 1'b0);
      n_cmp++; if (bus.fifo_count > CW'(1)) begin n_fail++; $display("FAIL held_count@%0d: got %0d want <=1", i, bus.fifo_count); end
    end
    for (int i = 0; i < FRAME + 4; i++) step(1'b0, 4'hE, 1'b0);
    n_cmp++; if (rx_q.size() !== 1) begin n_fail++; $display("FAIL held_frames: got %0d want 1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      n_cmp++; if (rx_q[0] !== 8'h2A) begin n_fail++; $display("FAIL held_char: got %h want 2a", rx_q[0]); end
    end
  endtask

  task automatic test_burst();
    logic [3:0] codes [3];
    logic [7:0] want [3];
    int maxc;
    codes[0] = 4'h1; codes[1] = 4'hA; codes[2] = 4'hF;
    want[0] = 8'h31; want[1] = 8'h41; want[2] = 8'h23;
    clear_logs();
    maxc = 0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, codes[k], 1'b0);
      if (int'(bus.fifo_count) > maxc) maxc = int'(bus.fifo_count);
      step(1'b0, codes[k], 1'b0);
      if (int'(bus.fifo_count) > maxc) maxc = int'(bus.fifo_count);
    end
    for (int i = 0; i < 3 * (FRAME + 1) + 4; i++) step(1'b0, 4'h0, 1'b0);
    n_cmp++; if (maxc !== 2) begin n_fail++; $display("FAIL burst_peak: got %0d want 2", maxc); end
    n_cmp++; if (rx_q.size() !== 3) begin n_fail++; $display("FAIL burst_frames: got %0d want 3", rx_q.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < rx_q.size()) begin
        n_cmp++; if (rx_q[k] !== want[k]) begin n_fail++; $display("FAIL burst_char[%0d]: got %h want %h", k, rx_q[k], want[k]); end
      end
    end
    for (int k = 1; k < rise_cyc.size(); k++) begin
      n_cmp++; if (rise_cyc[k] - rise_cyc[k-1] !== FRAME + 1) begin n_fail++; $display("FAIL burst_gap[%0d]: got %0d want %0d", k, rise_cyc[k] - rise_cyc[k-1], FRAME + 1); end
    end
  endtask

  task automatic test_overflow();
    step(1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b0);
    clear_logs();
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 4'(k), 1'b0);
      if (k == 4) begin
        n_cmp++; if (bus.fifo_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full5: got %b want 1", bus.fifo_full); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", bus.overflow); end
      end
      if (k == 5) begin
        n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
        n_cmp++; if (bus.fifo_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL ovf_count: got %0d want %0d", bus.fifo_count, DEPTH); end
      end
      step(1'b0, 4'(k), 1'b0);
    end
    for (int i = 0; i < 5 * (FRAME + 1) + 8; i++) step(1'b0, 4'h0, 1'b0);
    n_cmp++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
    n_cmp++; if (rx_q.size() !== 5) begin n_fail++; $display("FAIL ovf_frames: got %0d want 5", rx_q.size()); end
    for (int k = 0; k < 5; k++) begin
      if (k < rx_q.size()) begin
        n_cmp++; if (rx_q[k] !== ascii_ref(4'(k))) begin n_fail++; $display("FAIL ovf_char[%0d]: got %h want %h", k, rx_q[k], ascii_ref(4'(k))); end
      end
    end
    step(1'b0, 4'h0, 1'b1);
    n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
    step(1'b0, 4'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int busy_seen;
    clear_logs();
    step(1'b1, 4'h7, 1'b0); step(1'b0, 4'h7, 1'b0);
    step(1'b1, 4'h8, 1'b0); step(1'b0, 4'h8, 1'b0);
    step(1'b1, 4'h9, 1'b0); step(1'b0, 4'h9, 1'b0);
    for (int i = 0; i < 13; i++) step(1'b0, 4'h0, 1'b0);
    n_cmp++; if (bus.fifo_count !== CW'(2)) begin n_fail++; $display("FAIL mid_queued: got %0d want 2", bus.fifo_count); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", bus.busy); end
    step(1'b0, 4'h0, 1'b1);
    n_cmp++; if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL mid_rst_tx: got %b want 1", bus.tx); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.fifo_count !== CW'(0)) begin n_fail++; $display("FAIL mid_rst_count: got %0d want 0", bus.fifo_count); end
    n_cmp++; if (bus.rst_led !== 1'b0) begin n_fail++; $display("FAIL mid_rst_led: got %b want 0", bus.rst_led); end
    clear_logs();
    busy_seen = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(1'b0, 4'h0, 1'b0);
      if (bus.busy) busy_seen++;
    end
    n_cmp++; if (busy_seen !== 0) begin n_fail++; $display("FAIL mid_no_frame: got %0d busy cycles want 0", busy_seen); end
    n_cmp++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL mid_no_char: got %0d frames want 0", rx_q.size()); end
  endtask

  task automatic test_random();
    logic       key;
    logic [3:0] code;
    clear_logs();
    key = 1'b0;
    for (int i = 0; i < 1500 + 6 * (FRAME + 1); i++) begin
      if (i < 1500) begin
        key = ($urandom_range(0, 7) < 3) ? 1'b1 : 1'b0;
        code = 4'($urandom_range(0, 15));
      end else begin
        key = 1'b0;
        code = 4'h0;
      end
      step(key, code, 1'b0);
      n_cmp++; if (bus.tx !== exp_tx()) begin n_fail++; $display("FAIL rnd_tx@%0d: got %b want %b", i, bus.tx, exp_tx()); end
      n_cmp++; if (bus.busy !== (m_rem > 0)) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b want %b", i, bus.busy, m_rem > 0); end
      n_cmp++; if (bus.fifo_count !== CW'(m_q.size())) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, bus.fifo_count, m_q.size()); end
      n_cmp++; if (bus.fifo_full !== (m_q.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_full@%0d: got %b want %b", i, bus.fifo_full, m_q.size() == DEPTH); end
      n_cmp++; if (bus.overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %b want %b", i, bus.overflow, m_ovf); end
      n_cmp++; if (bus.rst_led !== m_led) begin n_fail++; $display("FAIL rnd_led@%0d: got %b want %b", i, bus.rst_led, m_led); end
    end
    n_cmp++; if (rx_q.size() !== m_sent.size()) begin n_fail++; $display("FAIL rnd_frames: got %0d want %0d", rx_q.size(), m_sent.size()); end
    for (int k = 0; k < m_sent.size(); k++) begin
      if (k < rx_q.size()) begin
        n_cmp++; if (rx_q[k] !== m_sent[k]) begin n_fail++; $display("FAIL rnd_char[%0d]: got %h want %h", k, rx_q[k], m_sent[k]); end
      end
    end
  endtask

  initial begin
    bus.transmit_key = 1'b0;
    bus.keypad_in = 4'h0;
    test_reset();
    test_single();
    test_parity();
    test_held();
    test_burst();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_uart_tx_fifo.md
# keypad_uart_tx_fifo

Parametrised keypad-to-UART transmitter that sits between the 4x4 keypad encoder and the board's serial TX pin. Each rising edge of the transmit key captures the current 4-bit key code, translates it to ASCII, and queues it in an internal FIFO. An integrated UART serialiser drains the FIFO back-to-back, so rapid key presses are not lost while a frame is in flight.

## Interface
- CLKS_PER_BIT, default 10417: clock cycles per UART bit (9600 baud at 100 MHz); legal values are ≥ 2.
- FIFO_DEPTH, default 8: number of queued characters; must be a power of two, ≥ 2.
- STOP_BITS, default 1: number of stop bits per frame; legal values are 1 or 2.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- keypad_in  in  4  encoded key; sampled in the same cycle the push is detected.
- transmit_key  in  1  level input, already synchronised; each 0→1 transition requests one character.
- tx  out  1  UART line; idles high.
- busy  out  1  high while a frame is being serialised.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of queued characters, not counting the frame in flight.
- fifo_full  out  1  high when fifo_count == FIFO_DEPTH.
- overflow  out  1  sticky flag, set when a push is dropped; cleared only by rst.
- rst_led  out  1  low during reset, high otherwise.

## Operation
- **Edge detect.** A register key_d tracks transmit_key. A push occurs in any cycle where transmit_key is 1 and key_d is 0. Holding the key produces exactly one push.
- **ASCII map.** The 4-bit code maps to a character as follows:
  - codes 0–9 map to 0x30–0x39;
  - A–D map to 0x41–0x44;
  - 0xE maps to 0x2A ('*');
  - 0xF maps to 0x23 ('#').
- **FIFO.**
  - Circular buffer with read and write pointers of width $clog2(FIFO_DEPTH); pointers wrap naturally.
  - A push while full is dropped, sets overflow, and leaves the contents unchanged.
  - If a push and a pop occur in the same cycle while full, both are accepted and the count is unchanged.
  - If a push arrives while the FIFO is empty, it is not popped in the same cycle.
- **FSM states.**
  - IDLE: tx=1 and busy=0. If fifo_count ≠ 0, pop the head into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A bit index counts 0..7. After bit 7 go to PARITY if enabled, otherwise STOP.
  - PARITY: present only with the parity macro; tx = even parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS×CLKS_PER_BIT cycles, then go to IDLE.
  - busy=1 in every state except IDLE.
- **Baud counter.** Counts 0..CLKS_PER_BIT−1 and clears on every state entry.
- **Reset values.** Applied on the edge where rst=1, regardless of the current state:
  - tx=1, busy=0, fifo_count=0, fifo_full=0, overflow=0, rst_led=0;
  - FSM=IDLE, pointers=0, key_d=0.
  - A frame in progress is aborted, the FIFO is flushed, and no partial character is resent.

## Timing
- Latency from push to start bit:
  - A push detected at edge E0 writes the FIFO at E0.
  - The FSM pops at E1, and tx=0 is visible after E1. Latency is 1 cycle from the capturing edge.
- Frame length is (10 + P + STOP_BITS − 1)×CLKS_PER_BIT cycles, where P=1 with parity, otherwise 0.
- Exactly one IDLE cycle separates back-to-back frames.
- fifo_count and fifo_full update on the edge of the push or pop.
- overflow asserts on the edge where the dropped push is detected.
- A 0→1 transition of transmit_key in the first cycle after reset release counts as a push, because key_d resets to 0.

## Configuration
- Macro: KEYPAD_UART_TX_PARITY_EN.
- Defined: the PARITY state is compiled in and every frame carries an even-parity bit after bit 7. The parity bit is the XOR of the 8 data bits.
- Undefined: there is no PARITY state; DATA goes directly to STOP.
- Port list and FIFO behaviour are identical in both builds.

## Test plan
- **Single character.** CLKS_PER_BIT=4, STOP_BITS=1, no parity, keypad_in=5, one pulse on transmit_key. Required: tx=0 one cycle after the push edge, then bits 1,0,1,0,1,1,0,0 (0x35, LSB first), each held 4 cycles, then tx=1. busy is high for 40 cycles.
- **Held key.** transmit_key held high for 200 cycles with keypad_in=0xE. Required: exactly one frame carrying 0x2A, and fifo_count never exceeds 1.
- **Burst.** Three pushes (0x1, 0xA, 0xF) in consecutive 2-cycle pulses. Required:
  - fifo_count peaks at 2;
  - frames 0x31, 0x41, 0x23 are sent in order, each separated by one idle cycle.
- **Overflow.** FIFO_DEPTH=4, CLKS_PER_BIT=16, six quick pushes. Required:
  - first character in flight, fifo_full=1 after the fifth push;
  - sixth push dropped and overflow=1 until rst;
  - exactly five frames sent.
- **Reset mid-frame.** Assert rst during DATA bit 3 with 2 characters queued. Required:
  - next edge: tx=1, busy=0, fifo_count=0, rst_led=0;
  - after release, no frame is sent.
- **Parity build.** With KEYPAD_UART_TX_PARITY_EN defined, keypad_in=1. Required: parity bit 1 (0x31 has three ones), and the frame lasts 11×CLKS_PER_BIT cycles.
